// File: rtl/sram_d_arbiter.sv
// Two-master round-robin OBI arbiter in front of the SRAM data port.
// Out-of-window accesses are answered locally; responses are routed in order via a small FIFO.
module sram_d_arbiter #(
  parameter logic [31:0] SRAM_BASE_ADDR  = 32'h8000_0000,
  parameter logic [31:0] SRAM_END_ADDR   = 32'h8000_C000,
  parameter int unsigned MAX_OUTSTANDING = 2
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        m0_req_i,
  input  logic        m1_req_i,
  output logic        m0_gnt_o,
  output logic        m1_gnt_o,
  input  logic [31:0] m0_addr_i,
  input  logic [31:0] m1_addr_i,
  input  logic        m0_we_i,
  input  logic        m1_we_i,
  input  logic [3:0]  m0_be_i,
  input  logic [3:0]  m1_be_i,
  input  logic [31:0] m0_wdata_i,
  input  logic [31:0] m1_wdata_i,
  output logic        m0_rvalid_o,
  output logic        m1_rvalid_o,
  output logic [31:0] m0_rdata_o,
  output logic [31:0] m1_rdata_o,
  output logic        m0_err_o,
  output logic        m1_err_o,
  output logic        sram_d_req_o,
  input  logic        sram_d_gnt_i,
  output logic [31:0] sram_d_addr_o,
  output logic        sram_d_we_o,
  output logic [3:0]  sram_d_be_o,
  output logic [31:0] sram_d_wdata_o,
  input  logic        sram_d_rvalid_i,
  input  logic [31:0] sram_d_rdata_i,
  output logic        illegal_memory_o
);

  localparam int unsigned PW = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
  localparam int unsigned CW = $clog2(MAX_OUTSTANDING + 1);
  localparam logic [CW-1:0] DEPTH    = CW'(MAX_OUTSTANDING);
  localparam logic [PW-1:0] LAST_IDX = PW'(MAX_OUTSTANDING - 1);

  logic                       last_q, last_d;
  logic [PW-1:0]              wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]              rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]              count_q, count_d;
  logic [MAX_OUTSTANDING-1:0] fid_q, fid_d;
  logic [MAX_OUTSTANDING-1:0] floc_q, floc_d;
  logic                       illegal_q, illegal_d;

  logic        any_req_s, sel_s, legal_s, fifo_empty_s, fifo_full_s;
  logic        head_id_s, head_local_s, fwd_s, local_gnt_s, gnt_s, pop_s;
  logic [31:0] sel_addr_s;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    if (p == LAST_IDX) begin
      ptr_inc = {PW{1'b0}};
    end else begin
      ptr_inc = p + PW'(1);
    end
  endfunction

  // Selection, address check and grant/pop decisions.
  // A local entry can only enter an empty FIFO and blocks further pushes, so it is
  // present exactly when it sits at the head.
  always_comb begin
    any_req_s = m0_req_i | m1_req_i;
    if (m0_req_i && m1_req_i) begin
      sel_s = ~last_q;
    end else if (m1_req_i) begin
      sel_s = 1'b1;
    end else begin
      sel_s = 1'b0;
    end
    sel_addr_s   = sel_s ? m1_addr_i : m0_addr_i;
    legal_s      = (sel_addr_s >= SRAM_BASE_ADDR) && (sel_addr_s < SRAM_END_ADDR);
    fifo_empty_s = (count_q == {CW{1'b0}});
    fifo_full_s  = (count_q == DEPTH);
    head_id_s    = fid_q[rd_ptr_q];
    head_local_s = ~fifo_empty_s & floc_q[rd_ptr_q];
    fwd_s        = ~rst_i & any_req_s & legal_s & ~fifo_full_s & ~head_local_s;
    local_gnt_s  = ~rst_i & any_req_s & ~legal_s & fifo_empty_s;
    gnt_s        = fwd_s ? sram_d_gnt_i : local_gnt_s;
    pop_s        = ~rst_i & ~fifo_empty_s & (head_local_s | sram_d_rvalid_i);
  end

  // Master-facing and SRAM-facing outputs.
  always_comb begin
    sram_d_req_o = fwd_s;
    if (fwd_s) begin
      sram_d_addr_o  = sel_addr_s;
      sram_d_we_o    = sel_s ? m1_we_i    : m0_we_i;
      sram_d_be_o    = sel_s ? m1_be_i    : m0_be_i;
      sram_d_wdata_o = sel_s ? m1_wdata_i : m0_wdata_i;
    end else begin
      sram_d_addr_o  = 32'h0000_0000;
      sram_d_we_o    = 1'b0;
      sram_d_be_o    = 4'b0000;
      sram_d_wdata_o = 32'h0000_0000;
    end
    m0_gnt_o    = gnt_s & ~sel_s;
    m1_gnt_o    = gnt_s & sel_s;
    m0_rvalid_o = pop_s & ~head_id_s;
    m1_rvalid_o = pop_s & head_id_s;
    m0_err_o    = m0_rvalid_o & head_local_s;
    m1_err_o    = m1_rvalid_o & head_local_s;
    if (pop_s && !head_local_s) begin
      m0_rdata_o = head_id_s ? 32'h0000_0000 : sram_d_rdata_i;
      m1_rdata_o = head_id_s ? sram_d_rdata_i : 32'h0000_0000;
    end else begin
      m0_rdata_o = 32'h0000_0000;
      m1_rdata_o = 32'h0000_0000;
    end
  end

  assign illegal_memory_o = illegal_q;

  // Next-state for round-robin pointer, routing FIFO and error pulse.
  always_comb begin
    last_d    = gnt_s ? sel_s : last_q;
    fid_d     = fid_q;
    floc_d    = floc_q;
    illegal_d = local_gnt_s;
    if (gnt_s) begin
      fid_d[wr_ptr_q]  = sel_s;
      floc_d[wr_ptr_q] = ~legal_s;
      wr_ptr_d         = ptr_inc(wr_ptr_q);
    end else begin
      wr_ptr_d = wr_ptr_q;
    end
    if (pop_s) begin
      rd_ptr_d = ptr_inc(rd_ptr_q);
    end else begin
      rd_ptr_d = rd_ptr_q;
    end
    case ({gnt_s, pop_s})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  // State registers.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      last_q    <= 1'b1;
      wr_ptr_q  <= {PW{1'b0}};
      rd_ptr_q  <= {PW{1'b0}};
      count_q   <= {CW{1'b0}};
      fid_q     <= {MAX_OUTSTANDING{1'b0}};
      floc_q    <= {MAX_OUTSTANDING{1'b0}};
      illegal_q <= 1'b0;
    end else begin
      last_q    <= last_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      count_q   <= count_d;
      fid_q     <= fid_d;
      floc_q    <= floc_d;
      illegal_q <= illegal_d;
    end
  end

endmodule

// File: tb/tb_sram_d_arbiter.sv
// Bench for sram_d_arbiter: directed scenarios with literal expectations, then random traffic,
// all cross-checked every cycle against a queue-based reference model.
module tb_sram_d_arbiter;

  localparam logic [31:0] BASE = 32'h8000_0000;
  localparam logic [31:0] ENDA = 32'h8000_C000;
  localparam int          MAXO = 2;

  logic        clk, rst;
  logic        m0_req, m1_req, m0_gnt, m1_gnt;
  logic [31:0] m0_addr, m1_addr, m0_wdata, m1_wdata;
  logic        m0_we, m1_we;
  logic [3:0]  m0_be, m1_be;
  logic        m0_rvalid, m1_rvalid, m0_err, m1_err;
  logic [31:0] m0_rdata, m1_rdata;
  logic        sram_req, sram_gnt, sram_we, sram_rvalid, illegal;
  logic [31:0] sram_addr, sram_wdata, sram_rdata;
  logic [3:0]  sram_be;

  sram_d_arbiter dut (
    .clk_i(clk), .rst_i(rst),
    .m0_req_i(m0_req), .m1_req_i(m1_req), .m0_gnt_o(m0_gnt), .m1_gnt_o(m1_gnt),
    .m0_addr_i(m0_addr), .m1_addr_i(m1_addr), .m0_we_i(m0_we), .m1_we_i(m1_we),
    .m0_be_i(m0_be), .m1_be_i(m1_be), .m0_wdata_i(m0_wdata), .m1_wdata_i(m1_wdata),
    .m0_rvalid_o(m0_rvalid), .m1_rvalid_o(m1_rvalid), .m0_rdata_o(m0_rdata), .m1_rdata_o(m1_rdata),
    .m0_err_o(m0_err), .m1_err_o(m1_err),
    .sram_d_req_o(sram_req), .sram_d_gnt_i(sram_gnt), .sram_d_addr_o(sram_addr),
    .sram_d_we_o(sram_we), .sram_d_be_o(sram_be), .sram_d_wdata_o(sram_wdata),
    .sram_d_rvalid_i(sram_rvalid), .sram_d_rdata_i(sram_rdata),
    .illegal_memory_o(illegal)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [159:0] act, input logic [159:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Reference model: queue of outstanding {master, local} in grant order.
  typedef struct packed { logic id; logic loc; } ent_t;
  ent_t mq[$];
  logic m_last = 1'b1;
  logic m_ill  = 1'b0;

  always @(negedge clk) begin : model
    logic        any, sel, legal, has_loc, fwd, g, pop, hid, err;
    logic [31:0] a, rdat;
    logic [67:0] exp_rsp;
    if (rst) begin
      chk("reset_outputs",
          {m0_gnt, m1_gnt, m0_rvalid, m1_rvalid, m0_err, m1_err, m0_rdata, m1_rdata,
           sram_req, sram_addr, sram_we, sram_be, sram_wdata, illegal}, 160'd0);
      mq.delete();
      m_last = 1'b1;
      m_ill  = 1'b0;
    end else begin
      any = m0_req | m1_req;
      if (m0_req && m1_req) sel = (m_last == 1'b1) ? 1'b0 : 1'b1;
      else sel = m1_req;
      a = sel ? m1_addr : m0_addr;
      legal = (a >= BASE) && (a < ENDA);
      has_loc = 1'b0;
      foreach (mq[i]) if (mq[i].loc) has_loc = 1'b1;
      fwd = any && legal && (mq.size() < MAXO) && !has_loc;
      g = fwd ? sram_gnt : (any && !legal && mq.size() == 0);
      chk("grant", {m0_gnt, m1_gnt}, {g && !sel, g && sel});
      chk("sram_req", sram_req, fwd);
      if (fwd)
        chk("fwd_fields", {sram_addr, sram_we, sram_be, sram_wdata},
            sel ? {m1_addr, m1_we, m1_be, m1_wdata} : {m0_addr, m0_we, m0_be, m0_wdata});
      pop = 1'b0; hid = 1'b0; err = 1'b0; rdat = 32'd0;
      if (mq.size() > 0) begin
        hid = mq[0].id;
        if (mq[0].loc) begin
          pop = 1'b1; err = 1'b1;
        end else if (sram_rvalid) begin
          pop = 1'b1; rdat = sram_rdata;
        end
      end
      exp_rsp = 68'd0;
      if (pop) exp_rsp = hid ? {34'd0, 1'b1, err, rdat} : {1'b1, err, rdat, 34'd0};
      chk("response", {m0_rvalid, m0_err, m0_rdata, m1_rvalid, m1_err, m1_rdata}, exp_rsp);
      chk("illegal_pulse", illegal, m_ill);
      if (pop) void'(mq.pop_front());
      if (g) begin
        mq.push_back('{id: sel, loc: !legal});
        m_last = sel;
      end
      m_ill = g && !legal;
    end
  end

  task automatic drive(input logic r0, input logic [31:0] a0, input logic r1, input logic [31:0] a1,
                       input logic g, input logic rv, input logic [31:0] rd);
    @(posedge clk);
    #1;
    m0_req = r0; m0_addr = a0; m0_we = 1'($urandom); m0_be = 4'($urandom); m0_wdata = $urandom;
    m1_req = r1; m1_addr = a1; m1_we = 1'($urandom); m1_be = 4'($urandom); m1_wdata = $urandom;
    sram_gnt = g; sram_rvalid = rv; sram_rdata = rd;
    #1;
  endtask

  function automatic logic [31:0] pick_addr();
    case ($urandom_range(0, 9))
      0: pick_addr = BASE;
      1: pick_addr = ENDA - 32'd4;
      2: pick_addr = ENDA;
      3: pick_addr = BASE - 32'd4;
      4: pick_addr = 32'h0000_0000;
      5: pick_addr = 32'hFFFF_FFFC;
      default: pick_addr = BASE + ($urandom_range(0, 32'h2FFF) << 2);
    endcase
  endfunction

  initial begin
    logic [31:0] bad_addr [2];
    bad_addr[0] = 32'h8000_C000;
    bad_addr[1] = 32'h7FFF_FFFC;
    rst = 1'b1;
    m0_req = 1'b0; m1_req = 1'b0; m0_addr = 32'd0; m1_addr = 32'd0;
    m0_we = 1'b0; m1_we = 1'b0; m0_be = 4'd0; m1_be = 4'd0; m0_wdata = 32'd0; m1_wdata = 32'd0;
    sram_gnt = 1'b0; sram_rvalid = 1'b0; sram_rdata = 32'd0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    // Reset asserted mid-cycle while m0 is being granted
    drive(1'b1, 32'h8000_0004, 1'b0, 32'd0, 1'b1, 1'b0, 32'd0);
    chk("pre_reset_gnt", m0_gnt, 1'b1);
    rst = 1'b1;
    #1;
    chk("reset_immediate", {m0_gnt, sram_req, sram_addr, m0_rvalid}, 35'd0);
    m0_req = 1'b0;
    @(posedge clk);
    #1 rst = 1'b0;

    drive(1'b1, 32'h8000_0004, 1'b0, 32'd0, 1'b1, 1'b0, 32'd0);
    chk("first_read_gnt", {m0_gnt, m1_gnt, sram_req, sram_addr}, {3'b101, 32'h8000_0004});
    drive(1'b0, 32'd0, 1'b0, 32'd0, 1'b0, 1'b1, 32'hCAFE_0004);
    chk("first_read_rsp", {m0_rvalid, m0_err, m0_rdata, m1_rvalid}, {2'b10, 32'hCAFE_0004, 1'b0});

    // Out-of-window reads answered locally
    for (int n = 0; n < 2; n++) begin
      drive(1'b0, 32'd0, 1'b1, bad_addr[n], 1'b1, 1'b0, 32'd0);
      chk("illegal_gnt", {m1_gnt, sram_req}, 2'b10);
      drive(1'b0, 32'd0, 1'b0, 32'd0, 1'b1, 1'b0, 32'd0);
      chk("illegal_rsp", {m1_rvalid, m1_err, m1_rdata, illegal}, {2'b11, 32'd0, 1'b1});
      drive(1'b0, 32'd0, 1'b0, 32'd0, 1'b1, 1'b0, 32'd0);
      chk("illegal_pulse_end", {illegal, m1_rvalid}, 2'b00);
    end

    // Round-robin with both masters requesting every cycle
    for (int k = 0; k < 7; k++) begin
      drive(k < 6, 32'h8000_1000 + 32'(k * 4), k < 6, 32'h8000_2000 + 32'(k * 4),
            1'b1, k > 0, 32'hD000_0000 + 32'(k));
      if (k < 6) chk("rr_gnt", {m0_gnt, m1_gnt}, (k % 2 == 0) ? 2'b10 : 2'b01);
      if (k > 0)
        chk("rr_rsp", {m0_rvalid, m1_rvalid, m0_rdata | m1_rdata},
            {((k - 1) % 2 == 0) ? 2'b10 : 2'b01, 32'hD000_0000 + 32'(k)});
    end

    // Ordering: legal m0 wins, illegal m1 waits for the FIFO to drain
    drive(1'b1, 32'h8000_0100, 1'b1, ENDA, 1'b1, 1'b0, 32'd0);
    chk("ord_first", {m0_gnt, m1_gnt}, 2'b10);
    drive(1'b0, 32'd0, 1'b1, ENDA, 1'b1, 1'b0, 32'd0);
    chk("ord_blocked", {m1_gnt, sram_req}, 2'b00);
    drive(1'b0, 32'd0, 1'b1, ENDA, 1'b1, 1'b1, 32'h1234_5678);
    chk("ord_m0_rsp", {m0_rvalid, m1_rvalid, m1_gnt, m0_rdata}, {3'b100, 32'h1234_5678});
    drive(1'b0, 32'd0, 1'b1, ENDA, 1'b1, 1'b0, 32'd0);
    chk("ord_local_gnt", m1_gnt, 1'b1);
    drive(1'b0, 32'd0, 1'b0, 32'd0, 1'b1, 1'b0, 32'd0);
    chk("ord_local_rsp", {m1_rvalid, m1_err, m0_rvalid, illegal}, 4'b1101);

    // Backpressure from the wrapper
    for (int k = 0; k < 3; k++) begin
      drive(1'b0, 32'd0, 1'b1, 32'h8000_0040, 1'b0, 1'b0, 32'd0);
      chk("bp_fwd", {sram_req, m1_gnt, sram_addr, sram_we, sram_be, sram_wdata},
          {2'b10, 32'h8000_0040, m1_we, m1_be, m1_wdata});
    end
    drive(1'b0, 32'd0, 1'b1, 32'h8000_0040, 1'b1, 1'b0, 32'd0);
    chk("bp_release", m1_gnt, 1'b1);
    drive(1'b0, 32'd0, 1'b0, 32'd0, 1'b0, 1'b1, 32'h0000_5555);
    chk("bp_rsp", {m1_rvalid, m1_rdata}, {1'b1, 32'h0000_5555});
    drive(1'b0, 32'd0, 1'b0, 32'd0, 1'b0, 1'b1, 32'h0000_6666);
    chk("spurious_rvalid", {m0_rvalid, m1_rvalid}, 2'b00);

    // FIFO full
    drive(1'b1, BASE + 32'd8, 1'b0, 32'd0, 1'b1, 1'b0, 32'd0);
    chk("full_g1", m0_gnt, 1'b1);
    drive(1'b1, BASE + 32'd8, 1'b0, 32'd0, 1'b1, 1'b0, 32'd0);
    chk("full_g2", m0_gnt, 1'b1);
    drive(1'b1, BASE + 32'd8, 1'b0, 32'd0, 1'b1, 1'b0, 32'd0);
    chk("full_withheld", {m0_gnt, sram_req}, 2'b00);
    drive(1'b0, 32'd0, 1'b0, 32'd0, 1'b1, 1'b1, 32'hAAAA_0001);
    chk("full_pop", {m0_rvalid, m0_rdata}, {1'b1, 32'hAAAA_0001});
    drive(1'b1, BASE + 32'd12, 1'b0, 32'd0, 1'b1, 1'b0, 32'd0);
    chk("full_regrant", m0_gnt, 1'b1);

    // Random traffic
    for (int i = 0; i < 3000; i++) begin
      drive($urandom_range(0, 9) < 7, pick_addr(), $urandom_range(0, 9) < 7, pick_addr(),
            $urandom_range(0, 9) < 7, $urandom_range(0, 3) <= ((i / 250) % 4), $urandom);
      if (i % 700 == 350) begin
        #1 rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
      end
    end

    @(posedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
